// File: rtl/seq_priority_encoder.sv
// seq_priority_encoder
// Sequential 8-to-3 priority encoder. A request word is captured on iLoad and
// the index of every set bit is emitted, one per valid/ready handshake, in
// priority order (highest first when HIGH_FIRST = 1, lowest first otherwise).
// Ports:
//   iClk    - system clock, rising edge
//   iRst_n  - synchronous active-low reset
//   iEna    - {G1,G2}; block enabled only when 2'b10
//   iLoad   - capture strobe for iData (honoured in IDLE while enabled)
//   iData   - request word D7..D0
//   iReady  - consumer accepts oData this cycle
//   oData   - index of the current pending bit (holds last value in IDLE)
//   oValid  - oData valid
//   oBusy   - pending bits remain (state EMIT)
//   oDone   - one-cycle pulse after the last index is accepted
//   oNone   - one-cycle pulse when a load captures an all-zero word
module seq_priority_encoder #(
    parameter bit HIGH_FIRST = 1'b1
) (
    input  logic       iClk,
    input  logic       iRst_n,
    input  logic [1:0] iEna,
    input  logic       iLoad,
    input  logic [7:0] iData,
    input  logic       iReady,
    output logic [2:0] oData,
    output logic       oValid,
    output logic       oBusy,
    output logic       oDone,
    output logic       oNone
);

    localparam int unsigned DATA_W = 8;
    localparam int unsigned IDX_W  = 3;

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    state_t              state;
    logic [DATA_W-1:0]   pending;

    logic                enabled;
    logic                handshake;
    logic [IDX_W-1:0]    curIdx;
    logic [IDX_W-1:0]    nextIdx;
    logic [IDX_W-1:0]    loadIdx;
    logic [DATA_W-1:0]   cleared;

    // Index of the winning set bit; returns 0 for an empty word (never used then).
    function automatic logic [IDX_W-1:0] prioIdx(input logic [DATA_W-1:0] v);
        logic [IDX_W-1:0] idx;
        logic             found;
        idx   = '0;
        found = 1'b0;
        for (int k = 0; k < int'(DATA_W); k++) begin
            if (v[k]) begin
                // Upward scan: last hit is the highest bit, first hit the lowest.
                if (HIGH_FIRST || !found) begin
                    idx = IDX_W'(k);
                end
                found = 1'b1;
            end
        end
        return idx;
    endfunction

    assign enabled   = (iEna == 2'b10);
    assign curIdx    = prioIdx(pending);
    assign cleared   = pending & ~(DATA_W'(1) << curIdx);
    assign nextIdx   = prioIdx(cleared);
    assign loadIdx   = prioIdx(iData);
    // A handshake needs the presented (registered) valid and a live enable.
    assign handshake = (state == EMIT) && enabled && oValid && iReady;

    // State, pending word and all registered outputs.
    always_ff @(posedge iClk) begin
        if (!iRst_n) begin
            state   <= IDLE;
            pending <= '0;
            oData   <= '0;
            oValid  <= 1'b0;
            oBusy   <= 1'b0;
            oDone   <= 1'b0;
            oNone   <= 1'b0;
        end else begin
            oDone <= 1'b0;
            oNone <= 1'b0;
            case (state)
                IDLE: begin
                    oValid <= 1'b0;
                    oBusy  <= 1'b0;
                    if (enabled && iLoad) begin
                        pending <= iData;
                        if (iData != '0) begin
                            state  <= EMIT;
                            oData  <= loadIdx;
                            oValid <= 1'b1;
                            oBusy  <= 1'b1;
                        end else begin
                            oNone <= 1'b1;
                        end
                    end
                end
                EMIT: begin
                    oBusy  <= 1'b1;
                    // Disable hides the output but freezes pending/oData.
                    oValid <= enabled;
                    if (handshake) begin
                        pending <= cleared;
                        if (cleared == '0) begin
                            state  <= IDLE;
                            oValid <= 1'b0;
                            oBusy  <= 1'b0;
                            oDone  <= 1'b1;
                        end else begin
                            oData <= nextIdx;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
